lsu_dport: RTL

- Load/store requester for the mox125 data memory port. It drives the dcache request interface (address, write data, write enable) and honours its stall.
- Sits between the pipeline memory stage and dcache.
- Converts byte, halfword and word loads and stores into the dcache's big-endian, 4-byte-wide accesses. Sub-word stores use read-modify-write.
- Reports completion, misalignment and load data back to the pipeline.

---
 rtl/lsu_dport.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_dport.sv
// lsu_dport: load/store requester for the mox125 data memory port.
// Converts byte/halfword/word loads and stores into 4-byte big-endian
// dcache accesses. Sub-word stores read the containing word, merge the
// new bytes in, and write the whole word back.

module lsu_dport #(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_req_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic [31:0] dc_address_o,
    output logic [31:0] dc_data_o,
    output logic        dc_we_o,
    input  logic [31:0] dc_data_i,
    input  logic        dc_stall_i
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    state_t      state;
    state_t      state_next;

    // Request attributes captured at accept time. Only the low half of the
    // store data is kept; word stores load dc_data_o directly from wdata_i.
    logic [1:0]  size_q;
    logic [15:0] wdata_q;
    logic        err_q;

    logic        misaligned;
    logic        reject;
    logic [31:0] load_value;
    logic [31:0] merge_value;

    // Classify the incoming request: misalignment and outright rejection
    always_comb begin
        misaligned = 1'b0;
        case (size_i)
            SIZE_HALF: misaligned = addr_i[0];
            SIZE_WORD: misaligned = |addr_i[1:0];
            default:   misaligned = 1'b0;
        endcase
        reject = (size_i == SIZE_BAD) || (CHECK_ALIGN && misaligned);
    end

    // Extract the load result and build the read-modify-write word; the
    // addressed byte is always the most significant byte of dc_data_i
    always_comb begin
        load_value  = dc_data_i;
        merge_value = {wdata_q, dc_data_i[15:0]};
        case (size_q)
            SIZE_BYTE: begin
                load_value  = {24'b0, dc_data_i[31:24]};
                merge_value = {wdata_q[7:0], dc_data_i[23:0]};
            end
            SIZE_HALF: begin
                load_value  = {16'b0, dc_data_i[31:16]};
                merge_value = {wdata_q, dc_data_i[15:0]};
            end
            default: begin
                load_value  = dc_data_i;
                merge_value = {wdata_q, dc_data_i[15:0]};
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs; dc_we_o depends on state only
    always_comb begin
        state_next = state;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        err_o      = 1'b0;
        dc_we_o    = 1'b0;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (req_i) begin
                    if (reject) begin
                        state_next = DONE;
                    end else if (!we_req_i) begin
                        state_next = RD;
                    end else if (size_i == SIZE_WORD) begin
                        state_next = WR;
                    end else begin
                        state_next = RMW_RD;
                    end
                end
            end
            RD: begin
                if (!dc_stall_i) begin
                    state_next = DONE;
                end
            end
            RMW_RD: begin
                if (!dc_stall_i) begin
                    state_next = WR;
                end
            end
            WR: begin
                dc_we_o = 1'b1;
                if (!dc_stall_i) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                err_o      = err_q;
                state_next = IDLE;
            end
            default: begin
                busy_o     = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers: capture the request, load result and write word
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            size_q       <= SIZE_BYTE;
            wdata_q      <= 16'h0;
            err_q        <= 1'b0;
            rdata_o      <= 32'h0;
            dc_address_o <= 32'h0;
            dc_data_o    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i) begin
                        size_q       <= size_i;
                        wdata_q      <= wdata_i[15:0];
                        err_q        <= reject;
                        dc_address_o <= addr_i;
                        if (we_req_i && (size_i == SIZE_WORD) && !reject) begin
                            dc_data_o <= wdata_i;
                        end
                    end
                end
                RD: begin
                    if (!dc_stall_i) begin
                        rdata_o <= load_value;
                    end
                end
                RMW_RD: begin
                    if (!dc_stall_i) begin
                        dc_data_o <= merge_value;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
